// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Holds the controller state encoding, the identification byte and
// the command-byte field layout.
package spi_ctrl_pkg;

  // Command byte: bit RW_BIT selects read (1) or write (0), the low
  // ADDR_W bits carry the starting register address.
  localparam int ADDR_W = 7;
  localparam int RW_BIT = 7;

  // Byte presented to the master while the command byte shifts in.
  localparam logic [7:0] ID_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_DATA  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between the SPI byte engine / register file and the controller.
// master: the controller's view; slave: the byte engine and register file side.
// No clock inside; all timing is owned by the modules using it.
interface spi_reg_ctrl_if;
  import spi_ctrl_pkg::*;

  // byte engine side
  logic              frame_start;
  logic              frame_end;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;

  // register file side
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  // status
  logic              busy;
  logic              err_overrun;

  modport master (
    input  frame_start, frame_end, rx_valid, rx_data, reg_rdata,
    output tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err_overrun
  );

  modport slave (
    output frame_start, frame_end, rx_valid, rx_data, reg_rdata,
    input  tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err_overrun
  );

endinterface

// File: rtl/spi_reg_ctrl.sv
// Purpose: decode SPI frames ({rw,addr} then data) into register-file burst reads/writes.
// Latency: write strobe 1 clk after rx_valid; read data on tx_data 2 clk after fetch starts.
// Backpressure: none; rx_valid during a pending read fetch only sets sticky err_overrun.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  spi_reg_ctrl_if.master    bus
);

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] ptr;
  logic [7:0]        tx_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              err_q;

  // decoded controls from the output process
  logic              ld_ptr;
  logic              commit_wr;
  logic              cap_tx;
  logic              set_id;
  logic              set_err;
  logic              re_c;
  logic              busy_c;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: a new frame_start aborts anything, frame_end always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (bus.frame_start) begin
      state_nxt = ST_CMD;
    end else if (bus.frame_end) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_IDLE;
        ST_CMD:      if (bus.rx_valid)
                       state_nxt = bus.rx_data[RW_BIT] ? ST_RD_FETCH : ST_WR_DATA;
        ST_WR_DATA:  state_nxt = ST_WR_DATA;
        ST_RD_FETCH: state_nxt = ST_RD_WAIT;
        ST_RD_WAIT:  state_nxt = ST_RD_DATA;
        ST_RD_DATA:  if (bus.rx_valid) state_nxt = ST_RD_FETCH;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // output decode: strobes and datapath enables for the current state
  always_comb begin
    ld_ptr    = 1'b0;
    commit_wr = 1'b0;
    cap_tx    = 1'b0;
    set_id    = bus.frame_start;
    set_err   = 1'b0;
    re_c      = 1'b0;
    busy_c    = (state != ST_IDLE);
    case (state)
      ST_CMD: begin
        ld_ptr = bus.rx_valid && !bus.frame_start;
      end
      ST_WR_DATA: begin
        // a byte arriving with frame_end is still committed; frame_start drops it
        commit_wr = bus.rx_valid && !bus.frame_start;
      end
      ST_RD_FETCH: begin
        re_c    = 1'b1;
        set_err = bus.rx_valid;
      end
      ST_RD_WAIT: begin
        cap_tx  = !bus.frame_start && !bus.frame_end;
        set_err = bus.rx_valid;
      end
      default: begin
      end
    endcase
  end

  // datapath: pointer, tx byte, write strobe/data and sticky overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      tx_q    <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= commit_wr;
      if (commit_wr) begin
        wdata_q <= bus.rx_data;
      end
      if (set_id) begin
        tx_q <= ID_BYTE;
      end else if (cap_tx) begin
        tx_q <= bus.reg_rdata;
      end
      // pointer advances after the write strobe cycle or with the read capture;
      // natural 7-bit wrap gives 127 -> 0
      if (ld_ptr) begin
        ptr <= bus.rx_data[ADDR_W-1:0];
      end else if (we_q || cap_tx) begin
        ptr <= ptr + 7'd1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.tx_data     = tx_q;
  assign bus.reg_addr    = ptr;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_re      = re_c;
  assign bus.busy        = busy_c;
  assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a register-file model and strobe scoreboard.
// Expected reg_we/reg_re strobes are queued as frames are driven and popped as they appear.
// Status and tx_data are checked inline at fixed points of the directed sequence.
module tb_spi_reg_ctrl;

  logic clk;
  logic reset;

  spi_reg_ctrl_if bus();

  spi_reg_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors;
  int         miscompares;
  logic [7:0] mem [0:127];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      5:       return 8'h3C;
      6:       return 8'h7E;
      7:       return 8'hC3;
      'h30:    return 8'h4D;
      default: return 8'h00;
    endcase
  endfunction

  // register file model: 1-clk read latency, writes on reg_we
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
      bus.reg_rdata <= 8'h00;
    end else begin
      if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
      if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.reg_we || bus.reg_re) begin
      exp_t e;
      chk("we_re_exclusive", {31'b0, bus.reg_we & bus.reg_re}, 32'd0);
      chk("strobe_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe_kind_we", {31'b0, bus.reg_we}, {31'b0, e.wr});
        chk("strobe_addr", 32'(bus.reg_addr), 32'(e.addr));
        if (e.wr) chk("strobe_wdata", 32'(bus.reg_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    bus.frame_end = 1'b1;
    tick(1);
    bus.frame_end = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(4);
  endtask

  task automatic push(input logic wr, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;

    // reset values
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tx", 32'(bus.tx_data), 32'h00);
    chk("rst_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    chk("rst_we", 32'(bus.reg_we), 32'd0);
    chk("rst_re", 32'(bus.reg_re), 32'd0);
    chk("rst_err", 32'(bus.err_overrun), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // byte in IDLE is ignored
    send(8'h05);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // write burst at 0x10
    push(1'b1, 7'h10, 8'h11);
    push(1'b1, 7'h11, 8'h22);
    pulse_start();
    chk("wr_busy", 32'(bus.busy), 32'd1);
    chk("wr_id", 32'(bus.tx_data), 32'hA5);
    send(8'h10);
    send(8'h11);
    send(8'h22);
    pulse_end();
    tick(1);
    chk("wr_end_busy", 32'(bus.busy), 32'd0);

    // read burst from 0x05
    push(1'b0, 7'h05, 8'h00);
    push(1'b0, 7'h06, 8'h00);
    push(1'b0, 7'h07, 8'h00);
    pulse_start();
    chk("rd_id", 32'(bus.tx_data), 32'hA5);
    send(8'h85);
    chk("rd_tx0", 32'(bus.tx_data), 32'h3C);
    send(8'h00);
    chk("rd_tx1", 32'(bus.tx_data), 32'h7E);
    send(8'h00);
    chk("rd_tx2", 32'(bus.tx_data), 32'hC3);
    pulse_end();
    tick(1);
    chk("rd_err", 32'(bus.err_overrun), 32'd0);

    // address wrap 0x7F -> 0x00
    push(1'b1, 7'h7F, 8'hAA);
    push(1'b1, 7'h00, 8'hBB);
    pulse_start();
    send(8'h7F);
    send(8'hAA);
    send(8'hBB);
    pulse_end();
    tick(2);

    // last data byte arriving together with frame_end is still written
    push(1'b1, 7'h20, 8'h55);
    pulse_start();
    send(8'h20);
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'h55;
    bus.frame_end = 1'b1;
    tick(1);
    bus.rx_valid  = 1'b0;
    bus.frame_end = 1'b0;
    chk("sim_busy", 32'(bus.busy), 32'd0);
    tick(4);

    // frame_start mid-read restarts in CMD with the ID byte
    push(1'b0, 7'h30, 8'h00);
    pulse_start();
    send(8'hB0);
    chk("abort_rd_tx", 32'(bus.tx_data), 32'h4D);
    pulse_start();
    chk("abort_busy", 32'(bus.busy), 32'd1);
    chk("abort_id", 32'(bus.tx_data), 32'hA5);
    tick(2);
    pulse_end();
    tick(1);
    chk("abort_end_busy", 32'(bus.busy), 32'd0);

    // overrun: second rx_valid while the fetch is pending
    push(1'b0, 7'h00, 8'h00);
    pulse_start();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h80;
    tick(2);
    bus.rx_valid = 1'b0;
    tick(3);
    chk("ovr_err", 32'(bus.err_overrun), 32'd1);
    chk("ovr_tx", 32'(bus.tx_data), 32'hBB);
    pulse_end();
    tick(5);
    chk("ovr_err_held", 32'(bus.err_overrun), 32'd1);

    // async reset in the middle of a write burst
    push(1'b1, 7'h40, 8'h01);
    pulse_start();
    send(8'h40);
    send(8'h01);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h02;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_tx", 32'(bus.tx_data), 32'h00);
    chk("arst_addr", 32'(bus.reg_addr), 32'd0);
    chk("arst_we", 32'(bus.reg_we), 32'd0);
    chk("arst_re", 32'(bus.reg_re), 32'd0);
    chk("arst_err", 32'(bus.err_overrun), 32'd0);
    tick(1);
    bus.rx_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    send(8'h81);
    tick(3);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
